// File: rtl/div_rem_unit_if.sv
// EX-stage request/response bundle between the pipeline and the divider.
// The pipeline drives the master side; the divider implements the slave side.
interface div_rem_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       alu_select;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             stall_req;

  modport master (
    output start, alu_select, operand_a, operand_b, flush,
    input  result, done, busy, stall_req
  );

  modport slave (
    input  start, alu_select, operand_a, operand_b, flush,
    output result, done, busy, stall_req
  );
endinterface

// File: rtl/div_rem_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Signs are stripped on entry and reapplied on exit; the core is unsigned.
module div_rem_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  div_rem_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             want_rem;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;

  // Operation decode and entry conditioning
  logic             is_divop;
  logic             signed_op;
  logic             rem_op;
  logic             accept;
  logic             div_by_zero;
  logic             overflow;
  logic             special;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] special_val;

  always_comb begin
    is_divop    = (bus.alu_select[4:2] == 3'b010);
    signed_op   = ~bus.alu_select[0];
    rem_op      = bus.alu_select[1];
    accept      = bus.start && (state == IDLE) && is_divop && !bus.flush;
    div_by_zero = (bus.operand_b == '0);
    overflow    = signed_op && (bus.operand_a == MIN_NEG) && (bus.operand_b == ALL_ONES);
    special     = div_by_zero || overflow;
    abs_a       = (signed_op && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
    abs_b       = (signed_op && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;
    if (div_by_zero) begin
      special_val = rem_op ? bus.operand_a : ALL_ONES;
    end else begin
      special_val = rem_op ? '0 : MIN_NEG;
    end
  end

  // One restoring step: the shifted partial remainder needs WIDTH+1 bits,
  // and the top bit of the difference doubles as the borrow flag.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] final_val;

  always_comb begin
    rem_sh    = {rem, quo[WIDTH-1]};
    diff      = rem_sh - {1'b0, divisor};
    borrow    = diff[WIDTH];
    rem_nxt   = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nxt   = {quo[WIDTH-2:0], ~borrow};
    if (want_rem) begin
      final_val = neg_r ? -rem_nxt : rem_nxt;
    end else begin
      final_val = neg_q ? -quo_nxt : quo_nxt;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (count == LAST_CNT) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (bus.flush) begin
      next_state = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (next_state == DONE);
      busy  <= (next_state == CALC);
    end
  end

  // Datapath registers: loaded on accept, stepped while calculating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      want_rem <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result   <= '0;
    end else if (accept) begin
      count    <= '0;
      rem      <= '0;
      quo      <= abs_a;
      divisor  <= abs_b;
      want_rem <= rem_op;
      neg_q    <= (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]) && signed_op && !div_by_zero;
      neg_r    <= bus.operand_a[WIDTH-1] && signed_op;
      if (special) begin
        result <= special_val;
      end
    end else if (state == CALC && !bus.flush) begin
      count <= count + 1'b1;
      rem   <= rem_nxt;
      quo   <= quo_nxt;
      if (count == LAST_CNT) begin
        result <= final_val;
      end
    end
  end

  assign bus.result    = result;
  assign bus.done      = done;
  assign bus.busy      = busy;
  assign bus.stall_req = accept || (state == CALC);

endmodule

// File: tb/tb_div_rem_unit.sv
// Directed-vector bench for div_rem_unit with hand-computed results.
module tb_div_rem_unit;

  localparam logic [4:0] OP_DIV  = 5'b01000;
  localparam logic [4:0] OP_DIVU = 5'b01001;
  localparam logic [4:0] OP_REM  = 5'b01010;
  localparam logic [4:0] OP_REMU = 5'b01011;
  localparam logic [4:0] OP_ADD  = 5'b00000;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  div_rem_unit_if #(.WIDTH(32)) bus ();

  div_rem_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns edges elapsed until done is seen (-1 on timeout)
  task automatic wait_done(output int edges, output int stalls);
    bit seen;
    seen   = 1'b0;
    edges  = 0;
    stalls = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.stall_req) stalls++;
        @(posedge clk);
        #1;
        edges++;
      end
    end
    if (!seen) edges = -1;
  endtask

  task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_edges);
    int edges;
    int stalls;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.alu_select = sel;
    bus.operand_a  = a;
    bus.operand_b  = b;
    #1;
    check({tag, "_stall_at_start"}, 32'(bus.stall_req), 32'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(edges, stalls);
    check({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    if (edges >= 0) begin
      check({tag, "_result"}, bus.result, exp_res);
      check({tag, "_stall_cycles"}, 32'(stalls + 1), 32'(exp_edges + 1));
      @(negedge clk);
      check({tag, "_done_pulse_width"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    int edges;
    int stalls;
    int done_cnt;
    logic any_busy;
    logic any_stall;
    logic any_done;
    checks   = 0;
    failures = 0;
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.alu_select = OP_ADD;
    bus.operand_a  = '0;
    bus.operand_b  = '0;
    bus.flush      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_result", bus.result, 32'h0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Main arithmetic cases
    run_op("div_pos_by_neg", OP_DIV,  32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 32);
    run_op("rem_neg_by_pos", OP_REM,  32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 32);
    run_op("divu_max_by_2",  OP_DIVU, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, 32);
    run_op("remu_max_by_2",  OP_REMU, 32'hFFFF_FFFF,  32'd2,         32'h0000_0001, 32);
    run_op("divu_min_by_max", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32);

    // Special cases finish without iterating
    run_op("div_by_zero",    OP_DIV,  32'd5,          32'd0,         32'hFFFF_FFFF, 0);
    run_op("remu_by_zero",   OP_REMU, 32'd5,          32'd0,         32'h0000_0005, 0);
    run_op("rem_neg_by_zero", OP_REM, 32'hFFFF_FF9C,  32'd0,         32'hFFFF_FF9C, 0);
    run_op("div_overflow",   OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_overflow",   OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 0);

    // Flush at count 10 aborts without a done pulse
    @(negedge clk);
    bus.start = 1'b1; bus.alu_select = OP_DIV; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    check("flush_busy_before", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy_after", 32'(bus.busy), 32'd0);
    check("flush_done_after", 32'(bus.done), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("flush_no_done", 32'(done_cnt), 32'd0);
    run_op("divu_after_flush", OP_DIVU, 32'd9, 32'd3, 32'd3, 32);

    // Flush dominates start in the same cycle
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.alu_select = OP_DIVU;
    #1;
    check("flush_blocks_accept", 32'(bus.stall_req), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_blocks_busy", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of a calculation
    @(negedge clk);
    bus.start = 1'b1; bus.alu_select = OP_DIV; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    check("pre_reset_result", bus.result, 32'd3);
    reset = 1'b0;
    #1;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_done", 32'(bus.done), 32'd0);
    check("midreset_result", bus.result, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Non-divide opcode is ignored
    bus.start = 1'b1; bus.alu_select = OP_ADD;
    any_busy = 1'b0; any_stall = 1'b0; any_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      any_busy  |= bus.busy;
      any_stall |= bus.stall_req;
      any_done  |= bus.done;
    end
    bus.start = 1'b0;
    check("add_no_busy", 32'(any_busy), 32'd0);
    check("add_no_stall", 32'(any_stall), 32'd0);
    check("add_no_done", 32'(any_done), 32'd0);

    // Back-to-back with start held through CALC and DONE
    @(negedge clk);
    bus.start = 1'b1; bus.alu_select = OP_REM; bus.operand_a = 32'd17; bus.operand_b = 32'd5;
    @(posedge clk); #1;
    bus.alu_select = OP_DIV;
    wait_done(edges, stalls);
    check("b2b_first_latency", 32'(edges), 32'd32);
    check("b2b_first_result", bus.result, 32'd2);
    @(posedge clk); #1;
    check("b2b_no_accept_in_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("b2b_second_stall", 32'(bus.stall_req), 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(edges, stalls);
    check("b2b_second_latency", 32'(edges), 32'd32);
    check("b2b_second_result", bus.result, 32'd3);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_rem_unit.md
Name: div_rem_unit

Overview:
- Iterative 32-cycle radix-2 restoring divider for the RV32M DIV, DIVU, REM and REMU operations.
- Sits in the EX stage beside the single-cycle ALU. It consumes the 5-bit alu_select code from the control unit (via the ID/EX register) plus the two forwarded operands.
- Raises a stall request to the hazard unit until its result is ready for the EX/MEM register.

Parameters:
- WIDTH, 32, operand and result width; the iteration count equals WIDTH.
- CNT_W, 5, iteration counter width; must equal clog2(WIDTH).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  EX-stage instruction valid, qualified by alu_select.
- alu_select  in  5  ALU op code. 01000=DIV, 01001=DIVU, 01010=REM, 01011=REMU; all other codes are ignored.
- operand_a  in  WIDTH  dividend (rs1 after forwarding).
- operand_b  in  WIDTH  divisor (rs2 after forwarding).
- flush  in  1  synchronous abort from branch/jump resolution.
- result  out  WIDTH  quotient or remainder; valid only while done=1.
- done  out  1  one-cycle pulse; result valid.
- busy  out  1  registered; high while state=CALC.
- stall_req  out  1  combinational: accept OR (state==CALC). Drives the hazard unit to freeze PC, IF/ID and ID/EX.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, count=0.
  - Remainder, quotient and divisor registers cleared.
  - result=0, done=0, busy=0.
- accept = start AND state==IDLE AND alu_select in {01000..01011} AND NOT flush.
  - start in CALC or DONE is ignored.
  - start with any other alu_select is ignored and produces no done.
- States: IDLE, CALC, DONE.
- IDLE, on accept edge k:
  - Latch op: signed = DIV/REM; want_rem = REM/REMU.
  - Latch |a| and |b| if signed, else raw values.
  - Latch neg_q = a[31]^b[31] AND signed AND b!=0; latch neg_r = a[31] AND signed.
  - Special cases, checked on the raw operands:
    - b==0: go to DONE, result = quotient all-ones (0xFFFFFFFF) or remainder = a.
    - signed AND a==0x80000000 AND b==0xFFFFFFFF: go to DONE, result = quotient 0x80000000 or remainder 0.
    - done is high in the cycle after edge k (latency 1).
  - Otherwise go to CALC, count=0.
- CALC, each edge:
  - Shift {rem,quo} left by 1.
  - Trial subtract rem-divisor (WIDTH+1 bits, borrow-aware). If non-negative, commit it and set quo[0]=1.
  - count increments. On the edge where count==WIDTH-1 completes, go to DONE and register result:
    - quotient, negated if neg_q; or
    - remainder, negated if neg_r.
  - done is high in the cycle after edge k+WIDTH (latency 32).
- DONE:
  - done=1 for exactly one cycle; next edge returns to IDLE.
  - result holds its value until the next load.
  - A new start in DONE is not accepted; the hazard unit keeps it stalled one more cycle via the IDLE path.
- flush=1 in any state: next edge goes to IDLE, done=0, no result is produced. Flush dominates start in the same cycle.
- Reset asserted mid-CALC: immediate return to reset values; deassertion resumes in IDLE.
- Arithmetic: unsigned core only; sign handling is done at entry (abs) and exit (two's-complement negate). The internal remainder is WIDTH+1 bits so the subtract never overflows.

Test Plan:
- DIV a=100, b=0xFFFFFFF9 (-7), start 1 cycle -> stall_req high for 33 cycles; done pulse 32 cycles after start; result=0xFFFFFFF2 (-14).
- REM a=0xFFFFFF9C (-100), b=7 -> result=0xFFFFFFFE (-2). DIVU a=0xFFFFFFFF, b=2 -> result=0x7FFFFFFF. REMU a=0xFFFFFFFF, b=2 -> result=1.
- DIV 5/0 -> done 1 cycle after start, result=0xFFFFFFFF. REMU 5%0 -> result=5. DIV 0x80000000/0xFFFFFFFF -> result=0x80000000. REM of the same operands -> result=0.
- DIV 100/7 started, flush asserted at CALC count=10 -> IDLE next cycle, no done pulse, busy=0. A following DIVU 9/3 -> result=3 after 32 cycles.
- reset pulled low at CALC count=20 -> busy, done and result all 0 immediately. start held high with alu_select=00000 (ADD) -> no busy, no stall_req, no done.
- Back-to-back: REM 17%5 then DIV 17/5, with start held during CALC -> the second op starts only after the first's DONE cycle; results are 2 then 3.
